// File: rtl/bus_cycle_pkg.sv
// Shared definitions for the local bus initiator and its lane steering logic.
package bus_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WDS     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_END     = 3'd5,
        ST_RECOVER = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LONG = 2'b00;

    localparam int TIMEOUT_DEFAULT  = 64;
    localparam int RECOVERY_DEFAULT = 1;

endpackage

// File: rtl/byte_lane_steer.sv
// Big-endian 68020 lane steering: write replication, read extraction and
// the size/alignment legality flag. Purely combinational.
module byte_lane_steer
    import bus_cycle_pkg::*;
(
    input  logic [1:0]  siz,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic [31:0] rdata,
    output logic        legal
);

    // Replicate the operand onto every lane and pick the addressed lane on reads.
    always_comb begin
        d_out = wdata;
        rdata = d_in;
        legal = 1'b1;
        case (siz)
            SIZ_BYTE: begin
                d_out = {4{wdata[7:0]}};
                case (addr_lo)
                    2'b00:   rdata = {24'h0, d_in[31:24]};
                    2'b01:   rdata = {24'h0, d_in[23:16]};
                    2'b10:   rdata = {24'h0, d_in[15:8]};
                    default: rdata = {24'h0, d_in[7:0]};
                endcase
            end
            SIZ_WORD: begin
                d_out = {2{wdata[15:0]}};
                rdata = addr_lo[1] ? {16'h0, d_in[15:0]} : {16'h0, d_in[31:16]};
                legal = ~addr_lo[0];
            end
            SIZ_LONG: begin
                legal = (addr_lo == 2'b00);
            end
            default: begin
                rdata = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_cycle_master.sv
// Local bus initiator running single asynchronous 68020-style cycles toward
// on-board responders, with timeout-to-bus-error and post-cycle recovery.
//
// state   | meaning
// IDLE    | bus negated, waiting for REQ with GRANT
// ADDR    | address/size/direction (and write data) driven, strobes negated
// STROBE  | AS20 asserted; DS20 too for reads
// WDS     | write only: DS20 asserted one clock after AS20
// WAIT    | waiting for TERM_N, timeout counter running
// END     | strobes negated, DONE pulse, write data still driven
// RECOVER | bus held negated before the next cycle may start
// ERR     | illegal request: DONE with BERR_OUT, no strobes
module bus_cycle_master
    import bus_cycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = TIMEOUT_DEFAULT,
    parameter int RECOVERY_CYCLES = RECOVERY_DEFAULT
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic [23:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZ,
    input  logic [31:0] REQ_WDATA,
    input  logic        GRANT,
    output logic        BUSY,
    output logic        DONE,
    output logic        BERR_OUT,
    output logic [31:0] RDATA,
    output logic [23:0] A,
    output logic [1:0]  SIZ,
    output logic        AS20,
    output logic        DS20,
    output logic        RW20,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic        TERM_N
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RC_W = $clog2(RECOVERY_CYCLES + 1);

    state_t        state, state_nxt;
    logic          wr_q;
    logic [23:0]   addr_q;
    logic [1:0]    siz_q;
    logic [31:0]   dout_q;
    logic [31:0]   rdata_q;
    logic          berr_q;
    logic [TO_W-1:0] to_cnt;
    logic [RC_W-1:0] rc_cnt;

    logic          accept;
    logic          to_done;
    logic          rc_done;
    logic [1:0]    steer_siz;
    logic [1:0]    steer_alo;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;
    logic          lane_legal;

    assign accept  = (state == ST_IDLE) && REQ && GRANT;
    assign to_done = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign rc_done = (rc_cnt == RC_W'(RECOVERY_CYCLES - 1));

    // In IDLE the steer judges the incoming request; afterwards it decodes the latched one.
    assign steer_siz = (state == ST_IDLE) ? REQ_SIZ       : siz_q;
    assign steer_alo = (state == ST_IDLE) ? REQ_ADDR[1:0] : addr_q[1:0];

    byte_lane_steer u_steer (
        .siz     (steer_siz),
        .addr_lo (steer_alo),
        .wdata   (REQ_WDATA),
        .d_in    (D_IN),
        .d_out   (lane_wdata),
        .rdata   (lane_rdata),
        .legal   (lane_legal)
    );

    // State register; reset drops straight to IDLE so strobes negate asynchronously.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and bus-signal decode.
    always_comb begin
        state_nxt = state;
        AS20      = 1'b1;
        DS20      = 1'b1;
        RW20      = 1'b1;
        D_OE      = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        BERR_OUT  = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (accept) state_nxt = lane_legal ? ST_ADDR : ST_ERR;
            end
            ST_ADDR: begin
                RW20      = ~wr_q;
                D_OE      = wr_q;
                state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                AS20      = 1'b0;
                DS20      = wr_q;
                RW20      = ~wr_q;
                D_OE      = wr_q;
                state_nxt = wr_q ? ST_WDS : ST_WAIT;
            end
            ST_WDS: begin
                AS20      = 1'b0;
                DS20      = 1'b0;
                RW20      = ~wr_q;
                D_OE      = wr_q;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                AS20 = 1'b0;
                DS20 = 1'b0;
                RW20 = ~wr_q;
                D_OE = wr_q;
                if (!TERM_N || to_done) state_nxt = ST_END;
            end
            ST_END: begin
                RW20      = ~wr_q;
                D_OE      = wr_q;
                DONE      = 1'b1;
                BERR_OUT  = berr_q;
                state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (rc_done) state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                DONE      = 1'b1;
                BERR_OUT  = 1'b1;
                state_nxt = ST_RECOVER;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, result capture and the WAIT/RECOVER counters.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            wr_q    <= 1'b0;
            addr_q  <= 24'h0;
            siz_q   <= 2'b00;
            dout_q  <= 32'h0;
            rdata_q <= 32'h0;
            berr_q  <= 1'b0;
            to_cnt  <= '0;
            rc_cnt  <= '0;
        end else begin
            if (accept) begin
                wr_q   <= REQ_WR;
                addr_q <= REQ_ADDR;
                siz_q  <= REQ_SIZ;
                dout_q <= lane_wdata;
                berr_q <= 1'b0;
                if (!lane_legal) rdata_q <= 32'h0;
            end
            if (state == ST_WAIT) begin
                if (!TERM_N) begin
                    rdata_q <= wr_q ? 32'h0 : lane_rdata;
                    berr_q  <= 1'b0;
                end else if (to_done) begin
                    rdata_q <= 32'h0;
                    berr_q  <= 1'b1;
                end
                if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (state == ST_RECOVER) begin
                if (rc_cnt != RC_W'(RECOVERY_CYCLES)) rc_cnt <= rc_cnt + 1'b1;
            end else begin
                rc_cnt <= '0;
            end
        end
    end

    assign A     = addr_q;
    assign SIZ   = siz_q;
    assign D_OUT = dout_q;
    assign RDATA = rdata_q;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master with hand-computed cycle timing.
module tb_bus_cycle_master;

    logic        CLKCPU = 1'b0;
    logic        RESET  = 1'b0;
    logic        REQ = 1'b0, REQ_WR = 1'b0;
    logic [23:0] REQ_ADDR = 24'h0;
    logic [1:0]  REQ_SIZ = 2'b00;
    logic [31:0] REQ_WDATA = 32'h0;
    logic        GRANT = 1'b1;
    logic        BUSY, DONE, BERR_OUT;
    logic [31:0] RDATA;
    logic [23:0] A;
    logic [1:0]  SIZ;
    logic        AS20, DS20, RW20;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic [31:0] D_IN = 32'h0;
    logic        TERM_N = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    bus_cycle_master #(.TIMEOUT_CYCLES(64), .RECOVERY_CYCLES(1)) dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .REQ(REQ), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_SIZ(REQ_SIZ), .REQ_WDATA(REQ_WDATA),
        .GRANT(GRANT), .BUSY(BUSY), .DONE(DONE), .BERR_OUT(BERR_OUT),
        .RDATA(RDATA), .A(A), .SIZ(SIZ), .AS20(AS20), .DS20(DS20),
        .RW20(RW20), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .TERM_N(TERM_N)
    );

    always #5 CLKCPU = ~CLKCPU;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-cycle observations, k = negedges after the accept edge.
    int          k_as_first, k_as_rise, k_ds_first, k_doe_last, k_done, n_done, n_as_low, k_busy_fall;
    logic [31:0] rd_done, a1, dout1;
    logic [1:0]  siz1, str_done;
    logic        berr_done, rw1, doe1;

    task automatic run_cycle(input logic wr, input logic [23:0] addr, input logic [1:0] siz,
                             input logic [31:0] wd, input int term_dly, input bit drop_grant);
        @(negedge CLKCPU);
        REQ = 1'b1; REQ_WR = wr; REQ_ADDR = addr; REQ_SIZ = siz; REQ_WDATA = wd;
        if (term_dly == -2) TERM_N = 1'b0;
        k_as_first = -1; k_as_rise = -1; k_ds_first = -1; k_doe_last = -1;
        k_done = -1; n_done = 0; n_as_low = 0; k_busy_fall = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLKCPU);
            if (k == 1) begin
                REQ = 1'b0;
                a1 = A; siz1 = SIZ; rw1 = RW20; dout1 = D_OUT; doe1 = D_OE;
            end
            if (!AS20) begin
                n_as_low++;
                if (k_as_first < 0) k_as_first = k;
            end else if (k_as_first >= 0 && k_as_rise < 0) begin
                k_as_rise = k;
            end
            if (!DS20 && k_ds_first < 0) k_ds_first = k;
            if (D_OE) k_doe_last = k;
            if (DONE) begin
                n_done++;
                if (k_done < 0) begin
                    k_done = k; rd_done = RDATA; berr_done = BERR_OUT; str_done = {AS20, DS20};
                end
                TERM_N = 1'b1;
            end
            if (term_dly >= 0 && k_as_first >= 0 && k == k_as_first + term_dly) TERM_N = 1'b0;
            if (drop_grant && k == 2) GRANT = 1'b0;
            if (!BUSY) begin
                k_busy_fall = k;
                break;
            end
        end
        GRANT = 1'b1;
        TERM_N = 1'b1;
        if (k_busy_fall < 0) check_vec("cycle_bound", 32'(k_busy_fall), 32'd0);
    endtask

    initial begin
        logic saw_done;
        int   gap, min_gap, dones;
        logic as_prev;

        // Reset values
        repeat (2) @(negedge CLKCPU);
        check_vec("rst_strobes", {29'h0, AS20, DS20, RW20}, 32'h7);
        check_vec("rst_addr_siz", {6'h0, A, SIZ}, 32'h0);
        check_vec("rst_dout", D_OUT, 32'h0);
        check_vec("rst_flags", {27'h0, D_OE, BUSY, DONE, BERR_OUT, 1'b0}, 32'h0);
        check_vec("rst_rdata", RDATA, 32'h0);
        RESET = 1'b1;
        repeat (2) @(negedge CLKCPU);

        // Read long, ready two clocks after AS20 falls
        D_IN = 32'hDEADBEEF;
        run_cycle(1'b0, 24'h200000, 2'b00, 32'h0, 2, 1'b0);
        check_vec("rl_addr", {8'h0, a1}, 32'h00200000);
        check_vec("rl_siz_rw", {29'h0, siz1, rw1}, 32'h1);
        check_vec("rl_as_low", 32'(n_as_low), 32'd3);
        check_vec("rl_ds_first", 32'(k_ds_first), 32'd2);
        check_vec("rl_done_k", 32'(k_done), 32'd5);
        check_vec("rl_done_cnt", 32'(n_done), 32'd1);
        check_vec("rl_rdata", rd_done, 32'hDEADBEEF);
        check_vec("rl_berr", {31'h0, berr_done}, 32'h0);
        check_vec("rl_busy_fall", 32'(k_busy_fall), 32'd7);

        // Write byte
        run_cycle(1'b1, 24'h200003, 2'b01, 32'h000000A5, 2, 1'b0);
        check_vec("wb_siz_rw", {29'h0, siz1, rw1}, 32'h2);
        check_vec("wb_dout", dout1, 32'hA5A5A5A5);
        check_vec("wb_doe_addr", {31'h0, doe1}, 32'h1);
        check_vec("wb_ds_lag", 32'(k_ds_first - k_as_first), 32'd1);
        check_vec("wb_as_rise", 32'(k_as_rise), 32'd5);
        check_vec("wb_doe_fall", 32'(k_doe_last + 1), 32'd6);
        check_vec("wb_berr", {31'h0, berr_done}, 32'h0);

        // Read byte / word lane extraction
        D_IN = 32'h11223344;
        run_cycle(1'b0, 24'h400002, 2'b01, 32'h0, 1, 1'b0);
        check_vec("rb_rdata", rd_done, 32'h00000033);
        check_vec("rb_done_k", 32'(k_done), 32'd4);
        run_cycle(1'b0, 24'h400002, 2'b10, 32'h0, 1, 1'b0);
        check_vec("rw_rdata", rd_done, 32'h00003344);

        // Misaligned word: error without strobes
        run_cycle(1'b0, 24'h200001, 2'b10, 32'h0, 1, 1'b0);
        check_vec("mis_done_k", 32'(k_done), 32'd1);
        check_vec("mis_berr", {31'h0, berr_done}, 32'h1);
        check_vec("mis_as_low", 32'(n_as_low), 32'd0);
        check_vec("mis_rdata", rd_done, 32'h0);
        check_vec("mis_busy_fall", 32'(k_busy_fall), 32'd3);

        // Illegal size code and misaligned long
        run_cycle(1'b1, 24'h200000, 2'b11, 32'h0, 1, 1'b0);
        check_vec("siz11_berr", {31'h0, berr_done}, 32'h1);
        check_vec("siz11_as_low", 32'(n_as_low), 32'd0);
        run_cycle(1'b0, 24'h200002, 2'b00, 32'h0, 1, 1'b0);
        check_vec("mislong_berr", {31'h0, berr_done}, 32'h1);

        // Timeout with TERM_N held high
        D_IN = 32'h11223344;
        run_cycle(1'b0, 24'h400000, 2'b01, 32'h0, 1, 1'b0);
        check_vec("pre_to_rdata", rd_done, 32'h00000011);
        run_cycle(1'b0, 24'h200004, 2'b00, 32'h0, -1, 1'b0);
        check_vec("to_done_k", 32'(k_done), 32'd67);
        check_vec("to_as_low", 32'(n_as_low), 32'd65);
        check_vec("to_berr", {31'h0, berr_done}, 32'h1);
        check_vec("to_rdata", rd_done, 32'h0);
        check_vec("to_strobes", {30'h0, str_done}, 32'h3);

        // Stale ready held low from before the request
        run_cycle(1'b0, 24'h400001, 2'b01, 32'h0, -2, 1'b0);
        check_vec("stale_done_k", 32'(k_done), 32'd4);
        check_vec("stale_as_low", 32'(n_as_low), 32'd2);
        check_vec("stale_rdata", rd_done, 32'h00000022);

        // Write word with GRANT dropping mid-cycle, then write long
        run_cycle(1'b1, 24'h200002, 2'b10, 32'h00001234, 2, 1'b1);
        check_vec("ww_dout", dout1, 32'h12341234);
        check_vec("ww_done", {16'(n_done), 16'(k_done)}, {16'd1, 16'd5});
        check_vec("ww_berr", {31'h0, berr_done}, 32'h0);
        run_cycle(1'b1, 24'h200008, 2'b00, 32'hCAFEF00D, 1, 1'b0);
        check_vec("wl_dout", dout1, 32'hCAFEF00D);
        check_vec("wl_done_k", 32'(k_done), 32'd5);

        // No start without GRANT
        @(negedge CLKCPU);
        GRANT = 1'b0; REQ = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 24'h200000; REQ_SIZ = 2'b00;
        repeat (4) @(negedge CLKCPU);
        check_vec("nogrant_busy", {30'h0, BUSY, AS20}, 32'h1);
        REQ = 1'b0; GRANT = 1'b1;

        // Reset asserted during WAIT of a write
        @(negedge CLKCPU);
        REQ = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 24'h200000; REQ_SIZ = 2'b00; REQ_WDATA = 32'h0F0F0F0F;
        @(negedge CLKCPU);
        REQ = 1'b0;
        repeat (3) @(negedge CLKCPU);
        check_vec("rstw_pre", {30'h0, AS20, D_OE}, 32'h1);
        #2 RESET = 1'b0;
        #1 check_vec("rstw_async", {28'h0, AS20, DS20, D_OE, BUSY}, 32'hC);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge CLKCPU);
            saw_done = saw_done | DONE;
        end
        RESET = 1'b1;
        repeat (3) begin
            @(negedge CLKCPU);
            saw_done = saw_done | DONE;
        end
        check_vec("rstw_no_done", {31'h0, saw_done}, 32'h0);

        // Back-to-back requests with REQ held high, ready always low
        TERM_N = 1'b0;
        REQ = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 24'h400000; REQ_SIZ = 2'b00;
        dones = 0; gap = 0; min_gap = 1000; as_prev = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge CLKCPU);
            if (DONE) dones++;
            if (AS20) gap++;
            else begin
                if (as_prev && k > 2 && gap < min_gap) min_gap = gap;
                gap = 0;
            end
            as_prev = AS20;
            if (k == 24) REQ = 1'b0;
        end
        TERM_N = 1'b1;
        check_vec("b2b_dones", 32'(dones), 32'd4);
        check_vec("b2b_min_gap", 32'(min_gap), 32'd4);
        repeat (4) @(negedge CLKCPU);
        check_vec("b2b_idle", {31'h0, BUSY}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
